// File: rtl/cordic_fix2float.sv
`default_nettype none
// ============================================================================
// Module   : cordic_fix2float
// Brief    : Converts the signed fixed-point CORDIC result into an IEEE-754
//            single-precision word. Three-stage valid/ready pipeline that
//            advances all stages together and accepts one value per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module cordic_fix2float #(
    parameter int FRACS = 20,
    parameter int INTS  = 1,
    parameter int WIDTH = INTS + FRACS + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_en,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_fixed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_float
);

    // Leading-one positions 0..23 always fit in five bits since WIDTH <= 24.
    localparam int c_pos_w    = 5;
    localparam int c_exp_bias = 127;

    logic               w_adv;
    logic               w_sign;
    logic [WIDTH-1:0]   w_mag;
    logic               w_zero;
    logic [c_pos_w-1:0] w_pos;
    logic [7:0]         w_exp;
    logic [23:0]        w_norm;
    logic [31:0]        w_float;

    logic               r_s1_valid;
    logic               r_s1_sign;
    logic [WIDTH-1:0]   r_s1_mag;
    logic               r_s1_zero;

    logic               r_s2_valid;
    logic               r_s2_sign;
    logic [WIDTH-1:0]   r_s2_mag;
    logic               r_s2_zero;
    logic [c_pos_w-1:0] r_s2_pos;

    logic               r_out_valid;
    logic [31:0]        r_out_float;

    // The whole pipeline moves as one unit whenever the output slot is free.
    assign w_adv     = clk_en && (!r_out_valid || out_ready);
    assign in_ready  = w_adv;
    assign out_valid = r_out_valid;
    assign out_float = r_out_float;

    // Stage 1 logic: sign/magnitude split; the most negative input maps to
    // 2^(WIDTH-1), which is still correct when read as unsigned.
    always_comb begin
        w_sign = in_fixed[WIDTH-1];
        w_mag  = w_sign ? -in_fixed : in_fixed;
        w_zero = (in_fixed == '0);
    end

    // Stage 2 logic: priority encoder, the highest set bit wins.
    always_comb begin
        w_pos = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (r_s1_mag[i]) begin
                w_pos = c_pos_w'(i);
            end
        end
    end

    // Stage 3 logic: bias the exponent, left-align bits below the leading one.
    always_comb begin
        w_exp   = 8'(c_exp_bias + int'(r_s2_pos) - FRACS);
        w_norm  = 24'(r_s2_mag) << (5'd23 - r_s2_pos);
        w_float = r_s2_zero ? 32'h0000_0000 : {r_s2_sign, w_exp, w_norm[22:0]};
    end

    // Pipeline registers: cleared asynchronously, shifted together on advance.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1_valid  <= 1'b0;
            r_s1_sign   <= 1'b0;
            r_s1_mag    <= '0;
            r_s1_zero   <= 1'b0;
            r_s2_valid  <= 1'b0;
            r_s2_sign   <= 1'b0;
            r_s2_mag    <= '0;
            r_s2_zero   <= 1'b0;
            r_s2_pos    <= '0;
            r_out_valid <= 1'b0;
            r_out_float <= 32'h0000_0000;
        end else if (w_adv) begin
            r_s1_valid  <= in_valid;
            r_s1_sign   <= w_sign;
            r_s1_mag    <= w_mag;
            r_s1_zero   <= w_zero;
            r_s2_valid  <= r_s1_valid;
            r_s2_sign   <= r_s1_sign;
            r_s2_mag    <= r_s1_mag;
            r_s2_zero   <= r_s1_zero;
            r_s2_pos    <= w_pos;
            r_out_valid <= r_s2_valid;
            r_out_float <= w_float;
        end
    end

endmodule
`default_nettype wire
